uart_alu_intf: RTL

UART_ALU_INTF -- requirements
Module: uart_alu_intf

---
 rtl/uart_alu_pkg.sv | 24 ++
 rtl/uart_alu_intf.sv | 119 +++++++++++
 2 files changed

// File: rtl/uart_alu_pkg.sv
// uart_alu_pkg
// Shared items for the UART <-> ALU bridge: the sequencer state encoding,
// default data/opcode widths and the position of the carry flag inside the
// byte returned to the host.
package uart_alu_pkg;

    // Default operand/result/UART byte width and opcode width.
    localparam int unsigned SIZEDATA_DEF = 8;
    localparam int unsigned SIZEOP_DEF   = 6;

    // The carry flag travels in bit 0 of an otherwise all-zero byte.
    localparam int unsigned CARRY_BIT    = 0;

    typedef enum logic [2:0] {
        RX_A     = 3'd0,
        RX_B     = 3'd1,
        RX_OP    = 3'd2,
        TX_RES   = 3'd3,
        WAIT_RES = 3'd4,
        TX_CRY   = 3'd5,
        WAIT_CRY = 3'd6
    } state_t;

endpackage

// File: rtl/uart_alu_intf.sv
// uart_alu_intf
// Sequencer between a UART and a combinational ALU. It collects three
// received bytes (operand A, operand B, opcode), presents them to the ALU,
// then sends back the result byte followed by a byte holding the carry flag.
//
// Ports:
//   CLK       clock, rising edge
//   RESET     asynchronous active-high reset
//   RX_DATA   received UART byte, valid while RX_DONE is high
//   RX_DONE   one-cycle pulse per received byte
//   RESULT    combinational ALU result
//   CARRY     combinational ALU carry
//   TX_DONE   one-cycle pulse when the transmitter finishes a byte
//   DATOA     registered operand A to the ALU
//   DATOB     registered operand B to the ALU
//   OPCODE    registered opcode to the ALU
//   TX_DATA   registered byte for the transmitter
//   TX_START  registered one-cycle transmit request
module uart_alu_intf
    import uart_alu_pkg::*;
#(
    parameter int unsigned SIZEDATA = SIZEDATA_DEF,
    parameter int unsigned SIZEOP   = SIZEOP_DEF
) (
    input  logic                CLK,
    input  logic                RESET,
    input  logic [SIZEDATA-1:0] RX_DATA,
    input  logic                RX_DONE,
    input  logic [SIZEDATA-1:0] RESULT,
    input  logic                CARRY,
    input  logic                TX_DONE,
    output logic [SIZEDATA-1:0] DATOA,
    output logic [SIZEDATA-1:0] DATOB,
    output logic [SIZEOP-1:0]   OPCODE,
    output logic [SIZEDATA-1:0] TX_DATA,
    output logic                TX_START
);

    state_t              state, state_nxt;
    logic [SIZEDATA-1:0] datoa_nxt, datob_nxt, tx_data_nxt;
    logic [SIZEOP-1:0]   opcode_nxt;
    logic                tx_start_nxt;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state    <= RX_A;
            DATOA    <= '0;
            DATOB    <= '0;
            OPCODE   <= '0;
            TX_DATA  <= '0;
            TX_START <= 1'b0;
        end else begin
            state    <= state_nxt;
            DATOA    <= datoa_nxt;
            DATOB    <= datob_nxt;
            OPCODE   <= opcode_nxt;
            TX_DATA  <= tx_data_nxt;
            TX_START <= tx_start_nxt;
        end
    end

    // Outputs are computed here as next-values and registered above, so
    // TX_START is high exactly in the cycle after TX_RES / TX_CRY.
    always_comb begin
        state_nxt    = state;
        datoa_nxt    = DATOA;
        datob_nxt    = DATOB;
        opcode_nxt   = OPCODE;
        tx_data_nxt  = TX_DATA;
        tx_start_nxt = 1'b0;

        case (state)
            RX_A: begin
                if (RX_DONE) begin
                    datoa_nxt = RX_DATA;
                    state_nxt = RX_B;
                end
            end
            RX_B: begin
                if (RX_DONE) begin
                    datob_nxt = RX_DATA;
                    state_nxt = RX_OP;
                end
            end
            RX_OP: begin
                if (RX_DONE) begin
                    // Upper bits of the opcode byte are dropped.
                    opcode_nxt = RX_DATA[SIZEOP-1:0];
                    state_nxt  = TX_RES;
                end
            end
            TX_RES: begin
                tx_data_nxt  = RESULT;
                tx_start_nxt = 1'b1;
                state_nxt    = WAIT_RES;
            end
            WAIT_RES: begin
                if (TX_DONE) begin
                    state_nxt = TX_CRY;
                end
            end
            TX_CRY: begin
                tx_data_nxt            = '0;
                tx_data_nxt[CARRY_BIT] = CARRY;
                tx_start_nxt           = 1'b1;
                state_nxt              = WAIT_CRY;
            end
            WAIT_CRY: begin
                if (TX_DONE) begin
                    state_nxt = RX_A;
                end
            end
            default: begin
                state_nxt = RX_A;
            end
        endcase
    end

endmodule
